masked_adder_pipe: RTL and testbench

- Parametrised, pipelined, first-order Boolean-masked (2-share) ripple-carry adder: the WIDTH-bit successor to the team's single-bit masked half adder.
- Adds two shared operands plus a shared carry-in and produces a shared sum and carry-out, with every nonlinear step in a registered domain-oriented-masking (DOM) AND gadget fed by fresh randomness.
- Sits between the masked datapath and PROLEAD evaluation harnesses.
- Accepts one transaction per cycle, valid-qualified, with no backpressure.

---
 rtl/masked_adder_pkg.sv | 18 +
 rtl/masked_adder_pipe_dom_and.sv | 37 +++
 rtl/masked_adder_pipe.sv | 155 +++++++++++++++
 tb/tb_masked_adder_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/masked_adder_pkg.sv
// Shared types and constants for the 2-share masked adder pipeline and its bench.
package masked_adder_pkg;

    localparam int NSHARES = 2;

    // Per-bit operand skew word: two shares of a, two shares of b, one random bit.
    localparam int OPBITS = 2 * NSHARES + 1;

    typedef struct packed {
        logic s0;
        logic s1;
    } share2_t;

    function automatic int adderLatency(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/masked_adder_pipe_dom_and.sv
// dom_and: one-cycle DOM-indep AND on 2-share inputs with registered inner and cross terms.
module dom_and
    import masked_adder_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  share2_t x_i,
    input  share2_t y_i,
    input  logic    r_i,
    output share2_t z_o
);

    share2_t inner_d, inner_q;
    share2_t cross_d, cross_q;

    // Cross terms are blinded by r before the register so the shares never meet unmasked.
    always_comb begin
        inner_d.s0 = x_i.s0 & y_i.s0;
        inner_d.s1 = x_i.s1 & y_i.s1;
        cross_d.s0 = (x_i.s0 & y_i.s1) ^ r_i;
        cross_d.s1 = (x_i.s1 & y_i.s0) ^ r_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inner_q <= '0;
            cross_q <= '0;
        end else begin
            inner_q <= inner_d;
            cross_q <= cross_d;
        end
    end

    assign z_o.s0 = inner_q.s0 ^ cross_q.s0;
    assign z_o.s1 = inner_q.s1 ^ cross_q.s1;

endmodule

// File: rtl/masked_adder_pipe.sv
// masked_adder_pipe: pipelined 2-share masked ripple-carry adder, one DOM AND per carry stage.
// Define MASKED_ADDER_REFRESH_EN to re-mask the output register with i_rnd_ref.
module masked_adder_pipe
    import masked_adder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_b0,
    input  logic [WIDTH-1:0] i_b1,
    input  logic             i_cin0,
    input  logic             i_cin1,
    input  logic [WIDTH-1:0] i_rnd,
    input  logic [WIDTH:0]   i_rnd_ref,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_sum0,
    output logic [WIDTH-1:0] o_sum1,
    output logic             o_carry0,
    output logic             o_carry1
);

    localparam int LAT = adderLatency(WIDTH);

    share2_t          cin_q;
    logic [WIDTH:0]   carry0;
    logic [WIDTH:0]   carry1;
    logic [WIDTH-1:0] sumTail0;
    logic [WIDTH-1:0] sumTail1;
    logic [LAT-1:0]   validSkew_q;

    logic [WIDTH-1:0] outSum0_d, outSum0_q;
    logic [WIDTH-1:0] outSum1_d, outSum1_q;
    logic             outCarry0_d, outCarry0_q;
    logic             outCarry1_d, outCarry1_q;
    logic             outValid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cin_q       <= '0;
            validSkew_q <= '0;
        end else begin
            cin_q       <= '{s0: i_cin0, s1: i_cin1};
            validSkew_q <= {validSkew_q[LAT-2:0], i_valid};
        end
    end

    assign carry0[0] = cin_q.s0;
    assign carry1[0] = cin_q.s1;

    // Stage k sees its operand bit after k+1 skew registers, in step with carry c_k.
    for (genvar k = 0; k < WIDTH; k++) begin : gStage
        logic [OPBITS-1:0]  opSkew_q [k+1];
        logic [NSHARES-1:0] sumSkew_q [WIDTH-k];
        logic [OPBITS-1:0]  op;
        share2_t            a, b, c, x, y, z, s;
        share2_t            cDel_q;

        assign op = opSkew_q[k];
        assign a  = '{s0: op[0], s1: op[1]};
        assign b  = '{s0: op[2], s1: op[3]};
        assign c  = '{s0: carry0[k], s1: carry1[k]};

        assign x = '{s0: a.s0 ^ c.s0, s1: a.s1 ^ c.s1};
        assign y = '{s0: b.s0 ^ c.s0, s1: b.s1 ^ c.s1};
        assign s = '{s0: a.s0 ^ b.s0 ^ c.s0, s1: a.s1 ^ b.s1 ^ c.s1};

        dom_and uAnd (
            .clk (clk),
            .rst (rst),
            .x_i (x),
            .y_i (y),
            .r_i (op[OPBITS-1]),
            .z_o (z)
        );

        // c_k is delayed one register so it lines up with the gadget output.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= k; j++) opSkew_q[j] <= '0;
                for (int j = 0; j < WIDTH - k; j++) sumSkew_q[j] <= '0;
                cDel_q <= '0;
            end else begin
                opSkew_q[0] <= {i_rnd[k], i_b1[k], i_b0[k], i_a1[k], i_a0[k]};
                for (int j = 1; j <= k; j++) opSkew_q[j] <= opSkew_q[j-1];
                sumSkew_q[0] <= {s.s1, s.s0};
                for (int j = 1; j < WIDTH - k; j++) sumSkew_q[j] <= sumSkew_q[j-1];
                cDel_q <= c;
            end
        end

        assign carry0[k+1] = z.s0 ^ cDel_q.s0;
        assign carry1[k+1] = z.s1 ^ cDel_q.s1;
        assign sumTail0[k] = sumSkew_q[WIDTH-k-1][0];
        assign sumTail1[k] = sumSkew_q[WIDTH-k-1][1];
    end

`ifdef MASKED_ADDER_REFRESH_EN
    logic [WIDTH:0] refSkew_q [LAT];
    logic [WIDTH:0] refTail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < LAT; j++) refSkew_q[j] <= '0;
        end else begin
            refSkew_q[0] <= i_rnd_ref;
            for (int j = 1; j < LAT; j++) refSkew_q[j] <= refSkew_q[j-1];
        end
    end

    assign refTail = refSkew_q[LAT-1];
`else
    logic unusedRef;
    assign unusedRef = ^i_rnd_ref;
`endif

    always_comb begin
        outSum0_d   = sumTail0;
        outSum1_d   = sumTail1;
        outCarry0_d = carry0[WIDTH];
        outCarry1_d = carry1[WIDTH];
`ifdef MASKED_ADDER_REFRESH_EN
        outSum0_d   = sumTail0 ^ refTail[WIDTH-1:0];
        outSum1_d   = sumTail1 ^ refTail[WIDTH-1:0];
        outCarry0_d = carry0[WIDTH] ^ refTail[WIDTH];
        outCarry1_d = carry1[WIDTH] ^ refTail[WIDTH];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outSum0_q   <= '0;
            outSum1_q   <= '0;
            outCarry0_q <= 1'b0;
            outCarry1_q <= 1'b0;
            outValid_q  <= 1'b0;
        end else begin
            outSum0_q   <= outSum0_d;
            outSum1_q   <= outSum1_d;
            outCarry0_q <= outCarry0_d;
            outCarry1_q <= outCarry1_d;
            outValid_q  <= validSkew_q[LAT-1];
        end
    end

    assign o_valid  = outValid_q;
    assign o_sum0   = outSum0_q;
    assign o_sum1   = outSum1_q;
    assign o_carry0 = outCarry0_q;
    assign o_carry1 = outCarry1_q;

endmodule

// File: tb/tb_masked_adder_pipe.sv
// Self-checking bench for masked_adder_pipe: unmasked-sum scoreboard plus directed share checks.
// Expectations for output refresh follow MASKED_ADDER_REFRESH_EN when it is defined.
module tb_masked_adder_pipe;
    import masked_adder_pkg::*;

    localparam int W   = 4;
    localparam int LAT = adderLatency(W);

`ifdef MASKED_ADDER_REFRESH_EN
    localparam logic [W-1:0] REF_SUM_DIFF   = 4'hF;
    localparam logic         REF_CARRY_DIFF = 1'b1;
`else
    localparam logic [W-1:0] REF_SUM_DIFF   = 4'h0;
    localparam logic         REF_CARRY_DIFF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic [W-1:0] i_a0, i_a1, i_b0, i_b1;
    logic         i_cin0, i_cin1;
    logic [W-1:0] i_rnd;
    logic [W:0]   i_rnd_ref;
    logic         o_valid;
    logic [W-1:0] o_sum0, o_sum1;
    logic         o_carry0, o_carry1;

    masked_adder_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_a0      (i_a0),
        .i_a1      (i_a1),
        .i_b0      (i_b0),
        .i_b1      (i_b1),
        .i_cin0    (i_cin0),
        .i_cin1    (i_cin1),
        .i_rnd     (i_rnd),
        .i_rnd_ref (i_rnd_ref),
        .o_valid   (o_valid),
        .o_sum0    (o_sum0),
        .o_sum1    (o_sum1),
        .o_carry0  (o_carry0),
        .o_carry1  (o_carry1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [W-1:0] sum;
        logic         carry;
    } exp_t;

    exp_t expQ[$];
    int   cyc     = 0;
    int   nChecks = 0;
    int   nFails  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: every accepted transaction yields A+B+cin exactly LAT edges later.
    always @(posedge clk) begin
        logic [W:0] full;
        cyc++;
        if (rst) begin
            expQ.delete();
        end else if (i_valid) begin
            full = (W+1)'(i_a0 ^ i_a1) + (W+1)'(i_b0 ^ i_b1) + (W+1)'(i_cin0 ^ i_cin1);
            expQ.push_back('{due: cyc + LAT, sum: full[W-1:0], carry: full[W]});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        logic expValid;
        if (rst) begin
            checkOutput("reset_outputs", 32'({o_valid, o_sum0, o_sum1, o_carry0, o_carry1}), 32'd0);
        end else begin
            expValid = (expQ.size() > 0) && (expQ[0].due == cyc);
            checkOutput("o_valid", 32'(o_valid), 32'(expValid));
            if (expValid) begin
                e = expQ.pop_front();
                if (o_valid) begin
                    checkOutput("sum", 32'(o_sum0 ^ o_sum1), 32'(e.sum));
                    checkOutput("carry", 32'(o_carry0 ^ o_carry1), 32'(e.carry));
                end
            end
        end
    end

    task automatic applyShares(input logic v,
                               input logic [W-1:0] a0, input logic [W-1:0] a1,
                               input logic [W-1:0] b0, input logic [W-1:0] b1,
                               input logic c0, input logic c1,
                               input logic [W-1:0] rnd, input logic [W:0] rref);
        i_valid   = v;
        i_a0      = a0;
        i_a1      = a1;
        i_b0      = b0;
        i_b1      = b1;
        i_cin0    = c0;
        i_cin1    = c1;
        i_rnd     = rnd;
        i_rnd_ref = rref;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin);
        logic [W-1:0] ma, mb;
        logic         mc;
        ma = W'($urandom);
        mb = W'($urandom);
        mc = 1'($urandom);
        applyShares(v, ma, a ^ ma, mb, b ^ mb, mc, cin ^ mc, W'($urandom), (W+1)'($urandom));
    endtask

    task automatic waitResult(input string name, output logic [W-1:0] s0, output logic [W-1:0] s1,
                              output logic c0, output logic c1);
        bit found;
        found   = 1'b0;
        i_valid = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (o_valid) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput({name, "_arrives"}, 32'(found), 32'd1);
        s0 = o_sum0;
        s1 = o_sum1;
        c0 = o_carry0;
        c1 = o_carry1;
    endtask

    task automatic resync();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] bs0, bs1, fs0, fs1, xs0, xs1, rs0, rs1, ts0, ts1;
        logic         bc0, bc1, fc0, fc1, xc0, xc1, rc0, rc1, tc0, tc1;

        rst = 1'b1;
        i_valid = 1'b0;
        i_a0 = '0; i_a1 = '0; i_b0 = '0; i_b1 = '0;
        i_cin0 = 1'b0; i_cin1 = 1'b0; i_rnd = '0; i_rnd_ref = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) resync();

        // 0x5 + 0x3 with zero gadget randomness.
        applyShares(1'b1, 4'h3, 4'h6, 4'hA, 4'h9, 1'b0, 1'b0, 4'h0, 5'h00);
        waitResult("basic", bs0, bs1, bc0, bc1);
        checkOutput("basic_sum", 32'(bs0 ^ bs1), 32'h8);
        checkOutput("basic_carry", 32'(bc0 ^ bc1), 32'h0);
        resync();

        // 0xF + 0x1 then 0x7 + 0x7 + 1, back to back.
        applyShares(1'b1, 4'h5, 4'hA, 4'h1, 4'h0, 1'b0, 1'b0, 4'h3, 5'h0C);
        applyShares(1'b1, 4'h2, 4'h5, 4'h4, 4'h3, 1'b1, 1'b0, 4'h9, 5'h11);
        waitResult("b2b_first", ts0, ts1, tc0, tc1);
        checkOutput("b2b_first_sum", 32'(ts0 ^ ts1), 32'h0);
        checkOutput("b2b_first_carry", 32'(tc0 ^ tc1), 32'h1);
        @(negedge clk);
        checkOutput("b2b_second_valid", 32'(o_valid), 32'h1);
        checkOutput("b2b_second_sum", 32'(o_sum0 ^ o_sum1), 32'hF);
        checkOutput("b2b_second_carry", 32'(o_carry0 ^ o_carry1), 32'h0);
        resync();

        // Same operand shares, different gadget randomness.
        applyShares(1'b1, 4'h3, 4'h6, 4'hA, 4'h9, 1'b0, 1'b0, 4'hF, 5'h00);
        waitResult("rnd_f", fs0, fs1, fc0, fc1);
        resync();
        applyShares(1'b1, 4'h3, 4'h6, 4'hA, 4'h9, 1'b0, 1'b0, 4'hA, 5'h00);
        waitResult("rnd_a", xs0, xs1, xc0, xc1);
        resync();
        checkOutput("rnd_f_sum", 32'(fs0 ^ fs1), 32'h8);
        checkOutput("rnd_a_sum", 32'(xs0 ^ xs1), 32'h8);
        checkOutput("rnd_f_carry", 32'(fc0 ^ fc1), 32'h0);
        checkOutput("rnd_f_share_low", 32'((fs0 ^ bs0) & 4'h3), 32'h2);
        checkOutput("rnd_a_share_low", 32'((xs0 ^ bs0) & 4'h7), 32'h4);

        // Output refresh mask against the unrefreshed basic run.
        applyShares(1'b1, 4'h3, 4'h6, 4'hA, 4'h9, 1'b0, 1'b0, 4'h0, 5'h1F);
        waitResult("refresh", rs0, rs1, rc0, rc1);
        resync();
        checkOutput("refresh_sum0_diff", 32'(rs0 ^ bs0), 32'(REF_SUM_DIFF));
        checkOutput("refresh_sum1_diff", 32'(rs1 ^ bs1), 32'(REF_SUM_DIFF));
        checkOutput("refresh_carry0_diff", 32'(rc0 ^ bc0), 32'(REF_CARRY_DIFF));
        checkOutput("refresh_sum", 32'(rs0 ^ rs1), 32'h8);
        checkOutput("refresh_carry", 32'(rc0 ^ rc1), 32'h0);

        // Bubble pattern 1,0,1,1.
        applyStimulus(1'b1, 4'h9, 4'h8, 1'b1);
        applyStimulus(1'b0, 4'h1, 4'h1, 1'b0);
        applyStimulus(1'b1, 4'hC, 4'h4, 1'b0);
        applyStimulus(1'b1, 4'h6, 4'hB, 1'b1);
        repeat (LAT + 3) applyStimulus(1'b0, W'($urandom), W'($urandom), 1'($urandom));

        // Reset with transactions in flight.
        applyStimulus(1'b1, 4'hE, 4'h7, 1'b1);
        applyStimulus(1'b1, 4'h3, 4'hD, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("reset_flush", 32'({o_valid, o_sum0, o_sum1, o_carry0, o_carry1}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (LAT + 3) applyStimulus(1'b0, W'($urandom), W'($urandom), 1'($urandom));

        for (int i = 0; i < 300; i++)
            applyStimulus($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), 1'($urandom));

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    applyStimulus(1'b1, W'(a), W'(b), 1'(c));

        repeat (LAT + 3) applyStimulus(1'b0, W'($urandom), W'($urandom), 1'($urandom));
        checkOutput("drain_empty", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
